// File: rtl/usb_boot_supervisor_if.sv
// Signal bundle between the USB protocol engine / bridge side and the boot supervisor.
// The supervisor connects through the slave modport; the driving side uses master.
interface usb_boot_supervisor_if;
  logic        sof_valid;
  logic        boot_req;
  logic [1:0]  boot_image;
  logic        stay_in_bootloader;
  logic        warmboot_boot;
  logic [1:0]  warmboot_sel;
  logic        host_present;
  logic [1:0]  state;
  logic [15:0] ms_count;

  // sof_valid and boot_req are single-cycle pulses, sampled on the rising clock edge.
  // There is no ready/back-pressure; a pulse is consumed in the cycle it is seen.
  modport master (
    output sof_valid, boot_req, boot_image, stay_in_bootloader,
    input  warmboot_boot, warmboot_sel, host_present, state, ms_count
  );

  modport slave (
    input  sof_valid, boot_req, boot_image, stay_in_bootloader,
    output warmboot_boot, warmboot_sel, host_present, state, ms_count
  );
endinterface

// File: rtl/usb_boot_supervisor.sv
// Watches SOF traffic to detect host attach/detach and decides when to leave the
// bootloader, driving the SB_WARMBOOT boot pulse and image select.
module usb_boot_supervisor #(
  parameter int CLK_HZ            = 48000000,
  parameter int ATTACH_TIMEOUT_MS = 20000,
  parameter int DETACH_TIMEOUT_MS = 100,
  parameter int PRESENT_SOFS      = 3,
  parameter int NUM_IMAGES        = 4,
  parameter int DEFAULT_IMAGE     = 1,
  parameter int BOOT_PULSE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  usb_boot_supervisor_if.slave bus
);

  localparam int PSC_DIV = CLK_HZ / 1000;
  localparam int PSC_W   = $clog2(PSC_DIV);
  localparam int PULSE_W = (BOOT_PULSE_CYCLES > 1) ? $clog2(BOOT_PULSE_CYCLES) : 1;

  localparam logic [PSC_W-1:0]   PSC_MAX    = PSC_W'(PSC_DIV - 1);
  localparam logic [PULSE_W-1:0] PULSE_MAX  = PULSE_W'(BOOT_PULSE_CYCLES - 1);
  localparam logic [15:0]        ATTACH_LIM = 16'(ATTACH_TIMEOUT_MS);
  localparam logic [15:0]        DETACH_LIM = 16'(DETACH_TIMEOUT_MS);
  localparam logic [3:0]         RUN_LIM    = 4'(PRESENT_SOFS);
  localparam logic [1:0]         DEF_SEL    = 2'(DEFAULT_IMAGE);

  typedef enum logic [1:0] {
    WAIT_HOST = 2'd0,
    PRESENT   = 2'd1,
    BOOT      = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t             cur_state, nxt_state;
  logic [PSC_W-1:0]   presc;
  logic               ms_tick;
  logic [15:0]        attach_cnt, gap_cnt;
  logic [3:0]         sof_run, sof_run_inc;
  logic [PULSE_W-1:0] pulse_cnt;
  logic [1:0]         sel_q, req_sel;
  logic               attach_to, detach_to, promote, enter_boot;

  always_comb begin
    ms_tick     = (presc == PSC_MAX);
    // SOFs closer than ~2 ms extend the run; a longer gap restarts it.
    if (gap_cnt <= 16'd2)
      sof_run_inc = (sof_run == 4'hF) ? 4'hF : sof_run + 4'd1;
    else
      sof_run_inc = 4'd1;
    attach_to   = (attach_cnt >= ATTACH_LIM) && !bus.stay_in_bootloader;
    detach_to   = (DETACH_TIMEOUT_MS != 0) && (gap_cnt >= DETACH_LIM) &&
                  !bus.stay_in_bootloader;
    promote     = bus.sof_valid && (sof_run_inc >= RUN_LIM);
    req_sel     = (32'(bus.boot_image) < NUM_IMAGES) ? bus.boot_image : DEF_SEL;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur_state <= WAIT_HOST;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; boot_req outranks timeouts, which outrank SOF promotion.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      WAIT_HOST: begin
        if (bus.boot_req || attach_to) nxt_state = BOOT;
        else if (promote)              nxt_state = PRESENT;
      end
      PRESENT:   if (bus.boot_req || detach_to) nxt_state = BOOT;
      BOOT:      if (pulse_cnt == PULSE_MAX)    nxt_state = DONE;
      DONE:      nxt_state = DONE;
      default:   nxt_state = WAIT_HOST;
    endcase
  end

  assign enter_boot = ((cur_state == WAIT_HOST) || (cur_state == PRESENT)) &&
                      (nxt_state == BOOT);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc      <= '0;
      attach_cnt <= '0;
      gap_cnt    <= '0;
      sof_run    <= '0;
      pulse_cnt  <= '0;
      sel_q      <= DEF_SEL;
    end else begin
      presc <= ms_tick ? '0 : presc + 1'b1;
      if (ms_tick && (attach_cnt != 16'hFFFF))
        attach_cnt <= attach_cnt + 16'd1;
      if (bus.sof_valid)
        gap_cnt <= '0;
      else if (ms_tick && (gap_cnt != 16'hFFFF))
        gap_cnt <= gap_cnt + 16'd1;
      if ((cur_state == WAIT_HOST) && bus.sof_valid)
        sof_run <= sof_run_inc;
      if (enter_boot) begin
        sel_q     <= bus.boot_req ? req_sel : DEF_SEL;
        pulse_cnt <= '0;
      end else if (cur_state == BOOT) begin
        pulse_cnt <= pulse_cnt + 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    bus.host_present  = (cur_state == PRESENT);
    bus.warmboot_boot = (cur_state == BOOT);
    bus.ms_count      = (cur_state == WAIT_HOST) ? attach_cnt : gap_cnt;
    bus.warmboot_sel  = sel_q;
    bus.state         = cur_state;
  end

endmodule
